data_memory_arbiter: RTL and testbench
======================================

// Module: data_memory_arbiter
// PURPOSE
//  Shares the single data_memory port (12b addr, 4b byteena, 32b data, 1-cycle registered read) between
//  requester 0 (core load/store stage) and requester 1 (DMA / debug loader). Grants one access per cycle.
//  Tags each read with its owner so read data returns one cycle later to the correct port.
//  Supports locked bursts, such as read-modify-write, with a bounded lock length so neither port starves.
// PARAMETERS
//  ADDR_W    12  address width, matching the data_memory address (bit 11 = IO write, bit 10 = IO read)
//  DATA_W    32  data width
//  LOCK_MAX  8   max consecutive grants to a locked owner while the other port is waiting (>=1)
// PORTS
//  clock        in   1       system clock, rising edge
//  reset        in   1       asynchronous, active-low reset
//  req0/req1    in   1       access request, held until gnt
//  lock0/lock1  in   1       keep ownership after this access (valid with req)
//  we0/we1      in   1       1 = write, 0 = read
//  addr0/addr1  in   ADDR_W  word/IO address
//  be0/be1      in   4       byte enables
//  wdata0/1     in   DATA_W  write data
//  gnt0/gnt1    out  1       access accepted this cycle (combinational from req/state)
//  rvalid0/1    out  1       read data valid on rdata0/1 (cycle after granted read)
//  rdata0/1     out  DATA_W  read data, 0 when rvalid low
//  mem_address  out  ADDR_W  to data_memory.address
//  mem_byteena  out  4       to data_memory.byteena
//  mem_data     out  DATA_W  to data_memory.data
//  mem_wren     out  1       to data_memory.wren
//  mem_q        in   DATA_W  from data_memory.q
// BEHAVIOUR
//  - Reset (reset=0): state IDLE; lock counter 0; last-grant pointer 1 (so port 0 wins first);
//    gnt*, rvalid*, mem_wren = 0; rdata* = 0. Takes effect immediately, independent of clock.
//  - Reset mid-operation: an in-flight read is dropped, with no rvalid after reset release.
//  - At most one gnt per cycle. Mem outputs mux the granted port's addr/be/wdata in the same cycle,
//    because data_memory registers its inputs. With no grant: mem_wren=0, other mem outputs hold port 0 values.
//  - mem_wren = gnt & we of the granted port.
//  - Read latency is 1: a granted read sets a registered owner tag; the next cycle, rvalid_owner=1 and
//    rdata_owner=mem_q. Writes never raise rvalid. Back-to-back reads from alternating ports are legal.
//  - FSM states: IDLE, LOCK0, LOCK1.
//    IDLE : arbitrate (see CONFIGURATION). If the winner has lock=1, go to LOCKx and set counter=1.
//    LOCKx: only port x is eligible.
//      x granted with lock=1 -> stay in LOCKx; counter +1 (saturates at LOCK_MAX).
//      x granted with lock=0, or x req low -> IDLE; counter 0.
//      counter==LOCK_MAX and other req=1 -> grant the other port this cycle (its lock ignored) -> IDLE.
//  - Counter advances only while the other port is requesting; otherwise it holds its value.
//  - Simultaneous req in IDLE resolves per CONFIGURATION; the pointer updates to the granted port on every grant.
// CONFIGURATION
//  DMEM_ARB_ROUND_ROBIN_EN defined:   IDLE tie goes to the port not granted last (pointer).
//  DMEM_ARB_ROUND_ROBIN_EN undefined: IDLE tie always goes to port 0. The pointer is still maintained but unused.
//  LOCK_MAX bound applies in both builds.
// STRUCTURE
//  Package dmem_arb_pkg holds:
//   - FSM state encoding (IDLE=2'd0, LOCK0=2'd1, LOCK1=2'd2)
//   - port index constants PORT_CORE=0, PORT_DMA=1
//   - default ADDR_W/DATA_W
//  One sub-module, dmem_arb_lock_timer: saturating up-counter with clear, enable and an at_max flag,
//  async active-low reset. All other logic is flat in this module.
// TESTING
//  1 Reset: reset=0 with req0=req1=1 -> gnt*=0, mem_wren=0, rvalid*=0.
//    Release -> first cycle gnt0=1 in both builds.
//  2 Read path: req0 read addr 0x010, mem_q=0xDEADBEEF next cycle -> rvalid0=1, rdata0=0xDEADBEEF,
//    rvalid1=0, rdata1=0.
//  3 Tie: req0=req1=1 (reads) for 4 cycles.
//    Fixed build: gnt0 x4. RR build: gnt0,gnt1,gnt0,gnt1, each rvalid on the correct port next cycle.
//  4 Lock: port 1 RMW read 0x020 lock=1, then write 0x020 lock=0, with req0=1 throughout
//    -> gnt1,gnt1, then gnt0. The write has mem_wren=1 and mem_byteena=be1.
//  5 Lock bound: LOCK_MAX=8, port 1 lock held, req0=1 -> 8 gnt1, then gnt0 on the 9th cycle, FSM IDLE.
//  6 Reset mid-read: granted read, then reset=0 before the next edge -> no rvalid after release.

Source files
------------

// File: rtl/data_memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared types and constants for the data memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam int PORT_CORE = 0;
    localparam int PORT_DMA  = 1;

    localparam int DEFAULT_ADDR_W = 12;
    localparam int DEFAULT_DATA_W = 32;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/data_memory_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_arbiter_if
//  Description : Requester and data_memory bus bundle around the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_memory_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic              req0,   req1;
    logic              lock0,  lock1;
    logic              we0,    we1;
    logic [ADDR_W-1:0] addr0,  addr1;
    logic [3:0]        be0,    be1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0,   gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;

    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteena;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    // Arbiter side
    modport slave (
        input  req0, req1, lock0, lock1, we0, we1, addr0, addr1,
               be0, be1, wdata0, wdata1, mem_q,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_address, mem_byteena, mem_data, mem_wren
    );

    // Requesters plus memory side
    modport master (
        output req0, req1, lock0, lock1, we0, we1, addr0, addr1,
               be0, be1, wdata0, wdata1, mem_q,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_address, mem_byteena, mem_data, mem_wren
    );

endinterface : data_memory_arbiter_if
`default_nettype wire

// File: rtl/data_memory_arbiter_lock_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_lock_timer
//  Description : Saturating lock-length counter with clear, enable, at_max.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_lock_timer #(
    parameter int LOCK_MAX = 8
) (
    input  wire logic i_clk,
    input  wire logic i_rst_n,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_at_max
);
    localparam int CNT_W = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(LOCK_MAX);

    logic [CNT_W-1:0] r_cnt;

    // Clear together with enable loads 1: the first grant of a new lock
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= i_en ? CNT_W'(1) : '0;
        end else if (i_en && (r_cnt != C_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_at_max = (r_cnt == C_MAX);

endmodule : dmem_arb_lock_timer
`default_nettype wire

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_arbiter
//  Description : Two-port arbiter for the data_memory port with bounded locks.
//                Define DMEM_ARB_ROUND_ROBIN_EN for round-robin idle ties.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int LOCK_MAX = 8
) (
    input  wire logic             clock,
    input  wire logic             reset,
    data_memory_arbiter_if.slave  bus
);
    state_t r_state;
    state_t w_state_nxt;
    logic   r_last;
    logic   r_rvalid0;
    logic   r_rvalid1;
    logic   w_gnt0;
    logic   w_gnt1;
    logic   w_tie_to1;
    logic   w_tmr_clr;
    logic   w_tmr_en;
    logic   w_at_max;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    assign w_tie_to1 = (r_last == 1'(PORT_CORE));
`else
    assign w_tie_to1 = 1'b0;
`endif

    // Grants are gated by reset so nothing reaches memory while it is held
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        w_tmr_clr   = 1'b0;
        w_tmr_en    = 1'b0;
        if (reset) begin
            case (r_state)
                IDLE: begin
                    if (bus.req0 && bus.req1) begin
                        w_gnt0 = ~w_tie_to1;
                        w_gnt1 = w_tie_to1;
                    end else begin
                        w_gnt0 = bus.req0;
                        w_gnt1 = bus.req1;
                    end
                    if (w_gnt0 && bus.lock0) begin
                        w_state_nxt = LOCK0;
                        w_tmr_clr   = 1'b1;
                        w_tmr_en    = 1'b1;
                    end else if (w_gnt1 && bus.lock1) begin
                        w_state_nxt = LOCK1;
                        w_tmr_clr   = 1'b1;
                        w_tmr_en    = 1'b1;
                    end
                end
                LOCK0: begin
                    if (w_at_max && bus.req1) begin
                        w_gnt1      = 1'b1;
                        w_state_nxt = IDLE;
                        w_tmr_clr   = 1'b1;
                    end else if (bus.req0) begin
                        w_gnt0 = 1'b1;
                        if (bus.lock0) begin
                            w_tmr_en = bus.req1;
                        end else begin
                            w_state_nxt = IDLE;
                            w_tmr_clr   = 1'b1;
                        end
                    end else begin
                        w_state_nxt = IDLE;
                        w_tmr_clr   = 1'b1;
                    end
                end
                LOCK1: begin
                    if (w_at_max && bus.req0) begin
                        w_gnt0      = 1'b1;
                        w_state_nxt = IDLE;
                        w_tmr_clr   = 1'b1;
                    end else if (bus.req1) begin
                        w_gnt1 = 1'b1;
                        if (bus.lock1) begin
                            w_tmr_en = bus.req0;
                        end else begin
                            w_state_nxt = IDLE;
                            w_tmr_clr   = 1'b1;
                        end
                    end else begin
                        w_state_nxt = IDLE;
                        w_tmr_clr   = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_tmr_clr   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_last    <= 1'(PORT_DMA);
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_gnt1 ? 1'(PORT_DMA) : (w_gnt0 ? 1'(PORT_CORE) : r_last);
            r_rvalid0 <= w_gnt0 & ~bus.we0;
            r_rvalid1 <= w_gnt1 & ~bus.we1;
        end
    end

    dmem_arb_lock_timer #(
        .LOCK_MAX (LOCK_MAX)
    ) u_lock_timer (
        .i_clk    (clock),
        .i_rst_n  (reset),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_at_max (w_at_max)
    );

    // Memory registers its inputs, so the granted port is muxed through now
    assign bus.mem_address = w_gnt1 ? bus.addr1  : bus.addr0;
    assign bus.mem_byteena = w_gnt1 ? bus.be1    : bus.be0;
    assign bus.mem_data    = w_gnt1 ? bus.wdata1 : bus.wdata0;
    assign bus.mem_wren    = (w_gnt0 & bus.we0) | (w_gnt1 & bus.we1);

    assign bus.gnt0    = w_gnt0;
    assign bus.gnt1    = w_gnt1;
    assign bus.rvalid0 = r_rvalid0;
    assign bus.rvalid1 = r_rvalid1;
    assign bus.rdata0  = r_rvalid0 ? bus.mem_q : '0;
    assign bus.rdata1  = r_rvalid1 ? bus.mem_q : '0;

endmodule : data_memory_arbiter
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory_arbiter
//  Description : Directed plus randomized check of data_memory_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_arbiter;

    localparam int LOCK_MAX = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    data_memory_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bif();

    data_memory_arbiter #(
        .ADDR_W   (12),
        .DATA_W   (32),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus state per port
    bit          s_req[2];
    bit          s_lock[2];
    bit          s_we[2];
    logic [11:0] s_addr[2];
    logic [3:0]  s_be[2];
    logic [31:0] s_wdata[2];
    logic [31:0] s_q;

    // Reference model: lock owner (-1 none), run length, last winner, pending read owner
    int m_owner, m_cnt, m_last, m_pend;
    int last_win;

    logic        obs_wren;
    logic [3:0]  obs_be;
    logic        obs_rvalid0, obs_rvalid1;
    logic [31:0] obs_rdata0, obs_rdata1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = 1;
        m_pend  = -1;
    endtask

    function automatic int model_winner();
        int o;
        if (m_owner < 0) begin
            if (s_req[0] && s_req[1]) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                return (m_last == 1) ? 0 : 1;
`else
                return 0;
`endif
            end
            if (s_req[0]) return 0;
            if (s_req[1]) return 1;
            return -1;
        end
        o = 1 - m_owner;
        if (m_cnt == LOCK_MAX && s_req[o]) return o;
        if (s_req[m_owner]) return m_owner;
        return -1;
    endfunction

    task automatic model_update(input int w);
        int o;
        if (m_owner < 0) begin
            if (w >= 0 && s_lock[w]) begin
                m_owner = w;
                m_cnt   = 1;
            end
        end else begin
            o = 1 - m_owner;
            if (w == m_owner && s_lock[w]) begin
                if (s_req[o] && m_cnt < LOCK_MAX) m_cnt++;
            end else begin
                m_owner = -1;
                m_cnt   = 0;
            end
        end
        if (w >= 0) m_last = w;
        m_pend = (w >= 0 && !s_we[w]) ? w : -1;
    endtask

    task automatic drive();
        bif.req0   = s_req[0];   bif.req1   = s_req[1];
        bif.lock0  = s_lock[0];  bif.lock1  = s_lock[1];
        bif.we0    = s_we[0];    bif.we1    = s_we[1];
        bif.addr0  = s_addr[0];  bif.addr1  = s_addr[1];
        bif.be0    = s_be[0];    bif.be1    = s_be[1];
        bif.wdata0 = s_wdata[0]; bif.wdata1 = s_wdata[1];
        bif.mem_q  = s_q;
    endtask

    // One clock: entered just after a rising edge, left just after the next one
    task automatic step();
        int w, sel;
        drive();
        @(negedge clock);
        w   = model_winner();
        sel = (w == 1) ? 1 : 0;
        check("gnt0", 32'(bif.gnt0), 32'(w == 0));
        check("gnt1", 32'(bif.gnt1), 32'(w == 1));
        check("mem_wren", 32'(bif.mem_wren), 32'(w >= 0 && s_we[sel]));
        check("mem_address", 32'(bif.mem_address), 32'(s_addr[sel]));
        check("mem_byteena", 32'(bif.mem_byteena), 32'(s_be[sel]));
        check("mem_data", bif.mem_data, s_wdata[sel]);
        check("rvalid0", 32'(bif.rvalid0), 32'(m_pend == 0));
        check("rvalid1", 32'(bif.rvalid1), 32'(m_pend == 1));
        check("rdata0", bif.rdata0, (m_pend == 0) ? s_q : 32'h0);
        check("rdata1", bif.rdata1, (m_pend == 1) ? s_q : 32'h0);
        obs_wren    = bif.mem_wren;
        obs_be      = bif.mem_byteena;
        obs_rvalid0 = bif.rvalid0;
        obs_rvalid1 = bif.rvalid1;
        obs_rdata0  = bif.rdata0;
        obs_rdata1  = bif.rdata1;
        @(posedge clock);
        model_update(w);
        last_win = w;
        #1;
    endtask

    task automatic set_port(input int p, input bit req, input bit lock, input bit we,
                            input logic [11:0] addr, input logic [3:0] be, input logic [31:0] wd);
        s_req[p]   = req;
        s_lock[p]  = lock;
        s_we[p]    = we;
        s_addr[p]  = addr;
        s_be[p]    = be;
        s_wdata[p] = wd;
    endtask

    task automatic new_req(input int p);
        set_port(p, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)), 12'($urandom), 4'($urandom), $urandom);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        s_req[0] = 1'b0;
        s_req[1] = 1'b0;
        drive();
        @(posedge clock);
        #1;
        check("rst_rvalid0", 32'(bif.rvalid0), 32'h0);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1, ninth;
        model_reset();
        last_win = -1;
        s_q = 32'h0;

        // Reset with both ports requesting
        set_port(0, 1'b1, 1'b0, 1'b0, 12'h001, 4'hF, 32'h0);
        set_port(1, 1'b1, 1'b0, 1'b0, 12'h002, 4'hF, 32'h0);
        drive();
        @(posedge clock);
        @(posedge clock);
        #1;
        check("t1_gnt0", 32'(bif.gnt0), 32'h0);
        check("t1_gnt1", 32'(bif.gnt1), 32'h0);
        check("t1_wren", 32'(bif.mem_wren), 32'h0);
        check("t1_rvalid0", 32'(bif.rvalid0), 32'h0);
        check("t1_rvalid1", 32'(bif.rvalid1), 32'h0);
        reset = 1'b1;
        model_reset();
        step();
        check("t1_first_win", 32'(last_win), 32'h0);

        // Read path
        apply_reset();
        set_port(0, 1'b1, 1'b0, 1'b0, 12'h010, 4'hF, 32'h0);
        set_port(1, 1'b0, 1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        step();
        s_req[0] = 1'b0;
        s_q = 32'hDEADBEEF;
        step();
        check("t2_rvalid0", 32'(obs_rvalid0), 32'h1);
        check("t2_rdata0", obs_rdata0, 32'hDEADBEEF);
        check("t2_rvalid1", 32'(obs_rvalid1), 32'h0);
        check("t2_rdata1", obs_rdata1, 32'h0);

        // Tie of two reads
        apply_reset();
        set_port(0, 1'b1, 1'b0, 1'b0, 12'h030, 4'hF, 32'h0);
        set_port(1, 1'b1, 1'b0, 1'b0, 12'h040, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            s_q = $urandom;
            step();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            check("t3_tie", 32'(last_win), 32'(i % 2));
`else
            check("t3_tie", 32'(last_win), 32'h0);
`endif
        end
        s_req[0] = 1'b0;
        s_req[1] = 1'b0;
        s_q = $urandom;
        step();

        // Locked read-modify-write from port 1
        apply_reset();
        set_port(0, 1'b0, 1'b0, 1'b0, 12'h100, 4'hF, 32'h0);
        set_port(1, 1'b1, 1'b1, 1'b0, 12'h020, 4'hF, 32'h0);
        step();
        check("t4_rd_win", 32'(last_win), 32'h1);
        s_req[0] = 1'b1;
        set_port(1, 1'b1, 1'b0, 1'b1, 12'h020, 4'b0110, 32'hCAFE0001);
        step();
        check("t4_wr_win", 32'(last_win), 32'h1);
        check("t4_wren", 32'(obs_wren), 32'h1);
        check("t4_be", 32'(obs_be), 32'h6);
        s_req[1] = 1'b0;
        step();
        check("t4_after_win", 32'(last_win), 32'h0);

        // Lock bound
        apply_reset();
        set_port(0, 1'b0, 1'b0, 1'b0, 12'h200, 4'hF, 32'h0);
        set_port(1, 1'b1, 1'b1, 1'b0, 12'h300, 4'hF, 32'h0);
        step();
        n1 = (last_win == 1) ? 1 : 0;
        ninth = -1;
        s_req[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_q = $urandom;
            step();
            if (last_win == 1) n1++;
            if (i == 7) ninth = last_win;
        end
        check("t5_gnt1_count", 32'(n1), 32'd8);
        check("t5_ninth_win", 32'(ninth), 32'h0);
        s_req[0] = 1'b0;
        step();
        check("t5_idle_win", 32'(last_win), 32'h1);
        s_req[1] = 1'b0;
        step();

        // Reset while a read is in flight
        apply_reset();
        set_port(0, 1'b1, 1'b0, 1'b0, 12'h050, 4'hF, 32'h0);
        drive();
        @(negedge clock);
        check("t6_gnt0", 32'(bif.gnt0), 32'h1);
        reset = 1'b0;
        #1;
        check("t6_gnt0_rst", 32'(bif.gnt0), 32'h0);
        @(posedge clock);
        #1;
        s_req[0] = 1'b0;
        drive();
        reset = 1'b1;
        model_reset();
        check("t6_no_rvalid", 32'(bif.rvalid0), 32'h0);
        step();

        // Randomized traffic
        new_req(0);
        new_req(1);
        for (int i = 0; i < 600; i++) begin
            s_q = $urandom;
            step();
            for (int p = 0; p < 2; p++) begin
                if (last_win == p || !s_req[p]) new_req(p);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_data_memory_arbiter
`default_nettype wire
